// File: rtl/log_reader_if.sv
// Handshake/bus bundle between the log reader, the log memory and the serial transmitter.
// The slave modport is the log reader; the master modport is its environment.
interface log_reader_if #(
    parameter int unsigned BRAM_ADDR_WIDTH = 15,
    parameter int unsigned BRAM_DATA_WIDTH = 16
);
    localparam int unsigned WORD_W = 2 * BRAM_DATA_WIDTH;

    logic                       i_start;
    logic                       i_mem_full;
    logic                       o_read_log;
    logic [BRAM_ADDR_WIDTH-1:0] o_addr_log_to_mem;
    logic [WORD_W-1:0]          i_data_log_from_mem;
    logic [7:0]                 o_tx_data;
    logic                       o_tx_valid;
    logic                       i_tx_ready;
    logic                       o_busy;
    logic                       o_done;

    modport master (
        output i_start,
        output i_mem_full,
        output i_data_log_from_mem,
        output i_tx_ready,
        input  o_read_log,
        input  o_addr_log_to_mem,
        input  o_tx_data,
        input  o_tx_valid,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_start,
        input  i_mem_full,
        input  i_data_log_from_mem,
        input  i_tx_ready,
        output o_read_log,
        output o_addr_log_to_mem,
        output o_tx_data,
        output o_tx_valid,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/log_reader.sv
// Dumps the full log memory, word by word, as a byte stream (LSB first) to a
// ready/valid serial transmitter once the logger reports the memory full.
module log_reader #(
    parameter int unsigned BRAM_ADDR_WIDTH = 15,
    parameter int unsigned BRAM_DATA_WIDTH = 16,
    parameter int unsigned RD_LATENCY      = 2
) (
    input logic        clk,
    input logic        i_rst,
    log_reader_if.slave bus
);
    localparam int unsigned WORD_W = 2 * BRAM_DATA_WIDTH;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT,
        LOAD,
        SEND,
        NEXT
    } state_e;

    state_e                     state_q;
    logic [BRAM_ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [IDX_W-1:0]           idx_q;
    logic [WORD_W-1:0]          sh_q;
    logic [7:0]                 tx_data_q;
    logic                       tx_valid_q;
    logic                       read_log_q;
    logic                       busy_q;
    logic                       done_q;

    logic                       xfer_c;
    logic                       last_addr_c;
    logic [BRAM_ADDR_WIDTH-1:0] addr_d;

    always_comb begin
        xfer_c      = tx_valid_q && bus.i_tx_ready;
        last_addr_c = (addr_q == {BRAM_ADDR_WIDTH{1'b1}});
        addr_d      = addr_q + BRAM_ADDR_WIDTH'(1);
    end

    // WAIT leaves when the counter reaches 1 (or 0), so the first word, whose
    // address is already on the bus during ARM, waits one cycle less.
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            sh_q       <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            read_log_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            read_log_q <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.i_start && bus.i_mem_full) begin
                        state_q    <= ARM;
                        read_log_q <= 1'b1;
                        addr_q     <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                ARM: begin
                    cnt_q   <= CNT_W'(RD_LATENCY - 1);
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= LOAD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                LOAD: begin
                    sh_q       <= bus.i_data_log_from_mem >> 8;
                    tx_data_q  <= bus.i_data_log_from_mem[7:0];
                    tx_valid_q <= 1'b1;
                    idx_q      <= '0;
                    state_q    <= SEND;
                end
                SEND: begin
                    if (xfer_c) begin
                        if (idx_q == IDX_W'(3)) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= NEXT;
                        end else begin
                            tx_data_q <= sh_q[7:0];
                            sh_q      <= sh_q >> 8;
                            idx_q     <= idx_q + IDX_W'(1);
                        end
                    end
                end
                NEXT: begin
                    if (last_addr_c) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        addr_q  <= addr_d;
                        cnt_q   <= CNT_W'(RD_LATENCY);
                        state_q <= WAIT;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_read_log        = read_log_q;
    assign bus.o_addr_log_to_mem = addr_q;
    assign bus.o_tx_data         = tx_data_q;
    assign bus.o_tx_valid        = tx_valid_q;
    assign bus.o_busy            = busy_q;
    assign bus.o_done            = done_q;

endmodule
